// File: rtl/multi_digit_code_lock.sv
// Multi-digit code lock: button-driven digit entry, stored code, retry limit and timed alarm.
// Buttons are synchronised and edge-detected; seg shows the digits currently being entered.
module multi_digit_code_lock #(
    parameter int NUM_DIGITS     = 4,
    parameter int DIGIT_MAX      = 9,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    localparam int SEL_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int LOCK_W        = $clog2(LOCKOUT_CYCLES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    btn_inc,
    input  logic                    btn_next,
    input  logic                    btn_enter,
    input  logic                    prog_req,
    output logic [7*NUM_DIGITS-1:0] seg,
    output logic [SEL_W-1:0]        sel,
    output logic [1:0]              lock_state,
    output logic [3:0]              fail_cnt
);

    typedef enum logic [1:0] {
        ST_PROGRAM  = 2'b00,
        ST_ARMED    = 2'b01,
        ST_UNLOCKED = 2'b10,
        ST_ALARM    = 2'b11
    } state_t;

    state_t                         state_q, state_d;
    logic [2:0]                     btn_raw, sync1_q, sync2_q, edge_q, pulse;
    logic [1:0]                     settle_q;
    logic [NUM_DIGITS-1:0][3:0]     entry_q, code_q;
    logic [SEL_W-1:0]               sel_q;
    logic [3:0]                     fail_q;
    logic [LOCK_W-1:0]              lock_cnt_q;
    logic                           can_edit, act_inc, act_next, act_enter, code_match;
    logic                           clear_entry, store_code, fail_clear, fail_step, lock_run;

    assign btn_raw = {btn_enter, btn_next, btn_inc};

    // Pulses stay masked until the sync chain has refilled after reset, so a
    // button held through reset release never looks like a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            edge_q   <= '0;
            settle_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
            if (settle_q != 2'b11)
                settle_q <= settle_q + 2'd1;
        end
    end

    assign pulse      = (settle_q == 2'b11) ? (sync2_q & ~edge_q) : 3'b000;
    assign can_edit   = (state_q == ST_PROGRAM) || (state_q == ST_ARMED);
    assign act_enter  = pulse[2] && (state_q != ST_ALARM);
    assign act_inc    = pulse[0] && !pulse[2] && can_edit;
    assign act_next   = pulse[1] && !pulse[2] && can_edit;
    assign code_match = (entry_q == code_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_PROGRAM;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        clear_entry = 1'b0;
        store_code  = 1'b0;
        fail_clear  = 1'b0;
        fail_step   = 1'b0;
        lock_run    = 1'b0;
        case (state_q)
            ST_PROGRAM: begin
                if (act_enter) begin
                    store_code  = 1'b1;
                    clear_entry = 1'b1;
                    state_d     = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (act_enter) begin
                    clear_entry = 1'b1;
                    if (code_match) begin
                        fail_clear = 1'b1;
                        state_d    = ST_UNLOCKED;
                    end else begin
                        fail_step = 1'b1;
                        if (fail_q + 4'd1 == 4'(MAX_TRIES))
                            state_d = ST_ALARM;
                    end
                end
            end
            ST_UNLOCKED: begin
                if (act_enter) begin
                    clear_entry = 1'b1;
                    state_d     = prog_req ? ST_PROGRAM : ST_ARMED;
                end
            end
            ST_ALARM: begin
                if (lock_cnt_q == LOCK_W'(LOCKOUT_CYCLES - 1)) begin
                    fail_clear = 1'b1;
                    state_d    = ST_ARMED;
                end else begin
                    lock_run = 1'b1;
                end
            end
            default: state_d = ST_PROGRAM;
        endcase
    end

    // Enter wins over inc/next, so a clear always leaves entry and sel at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
            code_q  <= '0;
            sel_q   <= '0;
        end else if (clear_entry) begin
            if (store_code)
                code_q <= entry_q;
            entry_q <= '0;
            sel_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (act_inc && (sel_q == SEL_W'(i)))
                    entry_q[i] <= (entry_q[i] == 4'(DIGIT_MAX)) ? 4'd0 : entry_q[i] + 4'd1;
            end
            if (act_next)
                sel_q <= (sel_q == SEL_W'(NUM_DIGITS - 1)) ? '0 : sel_q + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_q     <= '0;
            lock_cnt_q <= '0;
        end else begin
            if (fail_clear)
                fail_q <= '0;
            else if (fail_step)
                fail_q <= fail_q + 4'd1;
            lock_cnt_q <= lock_run ? lock_cnt_q + LOCK_W'(1) : '0;
        end
    end

    // Segment bits are {g,f,e,d,c,b,a}, active high.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_seg7
        assign seg[7*g +: 7] = seg7(entry_q[g]);
    end

    assign sel        = sel_q;
    assign lock_state = state_q;
    assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_multi_digit_code_lock.sv
// Directed scoreboard bench for multi_digit_code_lock (LOCKOUT_CYCLES = 16).
// Expected outputs are queued before each step and popped when the step has settled.
module tb_multi_digit_code_lock;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        btn_inc   = 1'b0;
    logic        btn_next  = 1'b0;
    logic        btn_enter = 1'b0;
    logic        prog_req  = 1'b0;
    logic [27:0] seg;
    logic [1:0]  sel;
    logic [1:0]  lock_state;
    logic [3:0]  fail_cnt;

    typedef struct {
        string       tag;
        logic [1:0]  lock;
        logic [3:0]  fails;
        logic [1:0]  sel;
        logic [27:0] seg;
    } exp_t;

    exp_t exp_q[$];
    int   vectors_applied = 0;
    int   miscompares     = 0;

    multi_digit_code_lock #(.LOCKOUT_CYCLES(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_inc   (btn_inc),
        .btn_next  (btn_next),
        .btn_enter (btn_enter),
        .prog_req  (prog_req),
        .seg       (seg),
        .sel       (sel),
        .lock_state(lock_state),
        .fail_cnt  (fail_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0:       return 7'h3F;
            1:       return 7'h06;
            2:       return 7'h5B;
            3:       return 7'h4F;
            4:       return 7'h66;
            5:       return 7'h6D;
            6:       return 7'h7D;
            7:       return 7'h07;
            8:       return 7'h7F;
            9:       return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    task automatic pushExp(input string tag, input logic [1:0] lock, input logic [3:0] fails,
                           input logic [1:0] s, input int d0, input int d1, input int d2, input int d3);
        exp_t e;
        e.tag   = tag;
        e.lock  = lock;
        e.fails = fails;
        e.sel   = s;
        e.seg   = {seg_of(d3), seg_of(d2), seg_of(d1), seg_of(d0)};
        exp_q.push_back(e);
    endtask

    // One button press: high for 'hold' cycles, then enough idle cycles for the action to land.
    task automatic applyStimulus(input logic inc, input logic nxt, input logic ent, input int hold);
        @(negedge clk);
        btn_inc   = inc;
        btn_next  = nxt;
        btn_enter = ent;
        repeat (hold) @(negedge clk);
        btn_inc   = 1'b0;
        btn_next  = 1'b0;
        btn_enter = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic enterDigits(input int d0, input int d1, input int d2, input int d3);
        int digs[4];
        digs = '{d0, d1, d2, d3};
        for (int i = 0; i < 4; i++) begin
            repeat (digs[i]) applyStimulus(1'b1, 1'b0, 1'b0, 1);
            if (i < 3)
                applyStimulus(1'b0, 1'b1, 1'b0, 1);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        vectors_applied++;
        assert (exp_q.size() > 0) else begin
            miscompares++;
            $error("[TB] FAIL scoreboard_empty got %0d entries want >0", exp_q.size());
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors_applied++;
            assert (lock_state === e.lock) else begin
                miscompares++;
                $error("[TB] FAIL %s lock_state got %b want %b", e.tag, lock_state, e.lock);
            end
            vectors_applied++;
            assert (fail_cnt === e.fails) else begin
                miscompares++;
                $error("[TB] FAIL %s fail_cnt got %0d want %0d", e.tag, fail_cnt, e.fails);
            end
            vectors_applied++;
            assert (sel === e.sel) else begin
                miscompares++;
                $error("[TB] FAIL %s sel got %0d want %0d", e.tag, sel, e.sel);
            end
            vectors_applied++;
            assert (seg === e.seg) else begin
                miscompares++;
                $error("[TB] FAIL %s seg got %h want %h", e.tag, seg, e.seg);
            end
        end
    endtask

    initial begin
        btn_inc = 1'b1;
        repeat (3) @(negedge clk);
        pushExp("reset", 2'b00, 4'd0, 2'd0, 0, 0, 0, 0);
        checkOutput();
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        btn_inc = 1'b0;
        repeat (5) @(negedge clk);
        pushExp("held_through_reset", 2'b00, 4'd0, 2'd0, 0, 0, 0, 0);
        checkOutput();

        pushExp("prog_first_inc", 2'b00, 4'd0, 2'd0, 1, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkOutput();
        pushExp("prog_first_next", 2'b00, 4'd0, 2'd1, 1, 0, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        checkOutput();
        pushExp("prog_digit1", 2'b00, 4'd0, 2'd1, 1, 2, 0, 0);
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkOutput();
        pushExp("prog_entry_full", 2'b00, 4'd0, 2'd3, 1, 2, 3, 4);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkOutput();
        pushExp("prog_commit", 2'b01, 4'd0, 2'd0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        checkOutput();

        enterDigits(1, 2, 3, 4);
        pushExp("unlock_1234", 2'b10, 4'd0, 2'd0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        checkOutput();
        pushExp("unlocked_ignores_edit", 2'b10, 4'd0, 2'd0, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        checkOutput();
        pushExp("relock", 2'b01, 4'd0, 2'd0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        checkOutput();

        pushExp("fail_1", 2'b01, 4'd1, 2'd0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        checkOutput();
        pushExp("fail_2", 2'b01, 4'd2, 2'd0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        checkOutput();
        pushExp("alarm_entered", 2'b11, 4'd3, 2'd0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        checkOutput();
        pushExp("alarm_ignores_inc", 2'b11, 4'd3, 2'd0, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkOutput();
        repeat (7) @(negedge clk);
        pushExp("alarm_last_cycle", 2'b11, 4'd3, 2'd0, 0, 0, 0, 0);
        checkOutput();
        @(negedge clk);
        pushExp("lockout_done", 2'b01, 4'd0, 2'd0, 0, 0, 0, 0);
        checkOutput();

        pushExp("digit_at_max", 2'b01, 4'd0, 2'd0, 9, 0, 0, 0);
        repeat (9) applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkOutput();
        pushExp("digit_wraps", 2'b01, 4'd0, 2'd0, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkOutput();
        pushExp("sel_at_last", 2'b01, 4'd0, 2'd3, 0, 0, 0, 0);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1);
        checkOutput();
        pushExp("sel_wraps", 2'b01, 4'd0, 2'd0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        checkOutput();
        pushExp("held_inc_once", 2'b01, 4'd0, 2'd0, 1, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 50);
        checkOutput();
        pushExp("check_after_hold", 2'b01, 4'd1, 2'd0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        checkOutput();
        pushExp("inc_next_same_cycle", 2'b01, 4'd1, 2'd1, 1, 0, 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1);
        checkOutput();
        pushExp("fail_with_1000", 2'b01, 4'd2, 2'd0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        checkOutput();
        enterDigits(1, 2, 3, 4);
        pushExp("enter_beats_inc", 2'b10, 4'd0, 2'd0, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1);
        checkOutput();

        prog_req = 1'b1;
        pushExp("to_program", 2'b00, 4'd0, 2'd0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        checkOutput();
        prog_req = 1'b0;
        enterDigits(9, 9, 9, 9);
        pushExp("prog_9999_entry", 2'b00, 4'd0, 2'd3, 9, 9, 9, 9);
        checkOutput();
        pushExp("prog_9999_commit", 2'b01, 4'd0, 2'd0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        checkOutput();
        enterDigits(9, 9, 9, 9);
        pushExp("unlock_9999", 2'b10, 4'd0, 2'd0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        checkOutput();

        pushExp("relock_2", 2'b01, 4'd0, 2'd0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        checkOutput();
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b1, 1);
        enterDigits(5, 0, 0, 0);
        pushExp("alarm_2", 2'b11, 4'd3, 2'd0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        checkOutput();
        #2 rst_n = 1'b0;
        #1;
        pushExp("reset_mid_alarm", 2'b00, 4'd0, 2'd0, 0, 0, 0, 0);
        checkOutput();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        pushExp("code_cleared_arm", 2'b01, 4'd0, 2'd0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        checkOutput();
        pushExp("code_cleared_unlock", 2'b10, 4'd0, 2'd0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        checkOutput();

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
